// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch controller.
//   - state_t    : controller state encoding (RUN / PAUSED / ADJUST)
//   - DIG_*      : bit positions of each display digit inside digit_blank
//   - BCD_W      : width of one BCD digit
//   - bcd_field_t: one two-digit BCD field (minutes or seconds)
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  // digit_blank bit order is {min_tens, min_ones, sec_tens, sec_ones}
  localparam int DIG_MIN_TENS = 3;
  localparam int DIG_MIN_ONES = 2;
  localparam int DIG_SEC_TENS = 1;
  localparam int DIG_SEC_ONES = 0;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_field_t;

endpackage

// File: rtl/stopwatch_ctrl_rise_detect.sv
// rise_detect: single-cycle rising-edge pulse from a clk-synchronous level.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   level - input level, already synchronous to clk
//   rise  - high for one cycle when level goes low->high
// The detector must see the level low at least once after reset before it
// can report a rise, so a level held high through reset never fires.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_q <= level;
      if (!level) armed <= 1'b1;
    end
  end

  assign rise = level & ~level_q & armed;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencer driving the MM:SS BCD time.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   clock1Hz, clock2Hz            - divided clock levels (count / adjust tick)
//   clockBlink                    - blink level, used only with BLINK_EN
//   btn_pause, btn_reset          - debounced buttons (rising edge acts)
//   sw_adj, sw_sel                - adjust mode switch, field select (1 = sec)
//   min_tens..sec_ones            - BCD time digits
//   running                       - 1 while in RUN
//   digit_blank                   - per-digit blank {min_tens,min_ones,sec_tens,sec_ones}
// Build option: define BLINK_EN to blink the selected field in ADJUST;
// otherwise digit_blank is tied to 0 and clockBlink is not used.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clock1Hz,
  input  logic             clock2Hz,
  input  logic             clockBlink,
  input  logic             btn_pause,
  input  logic             btn_reset,
  input  logic             sw_adj,
  input  logic             sw_sel,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic [3:0]       digit_blank
);

  localparam logic [BCD_W-1:0] MIN_MAX_T = BCD_W'(MAX_MIN / 10);
  localparam logic [BCD_W-1:0] MIN_MAX_O = BCD_W'(MAX_MIN % 10);
  localparam logic [BCD_W-1:0] SEC_MAX_T = BCD_W'(MAX_SEC / 10);
  localparam logic [BCD_W-1:0] SEC_MAX_O = BCD_W'(MAX_SEC % 10);
  localparam logic [BCD_W-1:0] BCD_ONE   = BCD_W'(1);
  localparam logic [BCD_W-1:0] BCD_NINE  = BCD_W'(9);

  function automatic logic at_max(input bcd_field_t f,
                                  input logic [BCD_W-1:0] mt,
                                  input logic [BCD_W-1:0] mo);
    return (f.tens == mt) && (f.ones == mo);
  endfunction

  // Two-digit BCD increment that wraps to 00 after the field maximum.
  function automatic bcd_field_t bcd_inc(input bcd_field_t f,
                                         input logic [BCD_W-1:0] mt,
                                         input logic [BCD_W-1:0] mo);
    bcd_field_t r;
    if (at_max(f, mt, mo)) begin
      r = '0;
    end else if (f.ones == BCD_NINE) begin
      r.tens = f.tens + BCD_ONE;
      r.ones = '0;
    end else begin
      r.tens = f.tens;
      r.ones = f.ones + BCD_ONE;
    end
    return r;
  endfunction

  logic tick1_rise, tick2_rise, pause_rise, reset_rise;

  rise_detect u_rd_tick1 (.clk(clk), .rst_n(rst_n), .level(clock1Hz),  .rise(tick1_rise));
  rise_detect u_rd_tick2 (.clk(clk), .rst_n(rst_n), .level(clock2Hz),  .rise(tick2_rise));
  rise_detect u_rd_pause (.clk(clk), .rst_n(rst_n), .level(btn_pause), .rise(pause_rise));
  rise_detect u_rd_reset (.clk(clk), .rst_n(rst_n), .level(btn_reset), .rise(reset_rise));

  state_t     state_reg;
  logic       saved_run_reg;
  logic       running_reg;
  bcd_field_t min_reg, sec_reg;
  bcd_field_t min_inc, sec_inc;
  logic       sec_wrap;
  logic       mode_change;

  assign min_inc  = bcd_inc(min_reg, MIN_MAX_T, MIN_MAX_O);
  assign sec_inc  = bcd_inc(sec_reg, SEC_MAX_T, SEC_MAX_O);
  assign sec_wrap = at_max(sec_reg, SEC_MAX_T, SEC_MAX_O);

  // sw_adj is a level: a change is pending whenever it disagrees with state.
  assign mode_change = sw_adj ^ (state_reg == ST_ADJUST);

  // Priority: reset_rise > mode change > pause_rise > tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_PAUSED;
      saved_run_reg <= 1'b0;
      running_reg   <= 1'b0;
      min_reg       <= '0;
      sec_reg       <= '0;
    end else if (reset_rise) begin
      min_reg     <= '0;
      sec_reg     <= '0;
      running_reg <= 1'b0;
      if (state_reg == ST_ADJUST) saved_run_reg <= 1'b0;
      else                        state_reg     <= ST_PAUSED;
    end else if (mode_change) begin
      // Any tick in this cycle is intentionally dropped.
      if (state_reg == ST_ADJUST) begin
        state_reg   <= saved_run_reg ? ST_RUN : ST_PAUSED;
        running_reg <= saved_run_reg;
      end else begin
        state_reg     <= ST_ADJUST;
        saved_run_reg <= (state_reg == ST_RUN);
        running_reg   <= 1'b0;
      end
    end else begin
      case (state_reg)
        ST_RUN: begin
          // A tick coinciding with pause is still counted.
          if (tick1_rise) begin
            sec_reg <= sec_inc;
            if (sec_wrap) min_reg <= min_inc;
          end
          if (pause_rise) begin
            state_reg   <= ST_PAUSED;
            running_reg <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (pause_rise) begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        end
        ST_ADJUST: begin
          // Field-local increment, no carry between fields.
          if (tick2_rise) begin
            if (sw_sel) sec_reg <= sec_inc;
            else        min_reg <= min_inc;
          end
        end
        default: begin
          state_reg   <= ST_PAUSED;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  assign min_tens = min_reg.tens;
  assign min_ones = min_reg.ones;
  assign sec_tens = sec_reg.tens;
  assign sec_ones = sec_reg.ones;
  assign running  = running_reg;

`ifdef BLINK_EN
  logic blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 1'b0;
    else        blink_q <= clockBlink;
  end

  always_comb begin
    digit_blank = '0;
    if (state_reg == ST_ADJUST && blink_q) begin
      if (sw_sel) begin
        digit_blank[DIG_SEC_TENS] = 1'b1;
        digit_blank[DIG_SEC_ONES] = 1'b1;
      end else begin
        digit_blank[DIG_MIN_TENS] = 1'b1;
        digit_blank[DIG_MIN_ONES] = 1'b1;
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = clockBlink;
  assign digit_blank  = '0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed stimulus with a queued scoreboard. Each
// stimulus step pushes the expected {time, running, digit_blank} for the
// cycle after its edge; an independent monitor pops and compares 1 time
// unit after every rising clk edge.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clock1Hz, clock2Hz, clockBlink;
  logic       btn_pause, btn_reset, sw_adj, sw_sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running;
  logic [3:0] digit_blank;

  stopwatch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .clock1Hz(clock1Hz), .clock2Hz(clock2Hz), .clockBlink(clockBlink),
    .btn_pause(btn_pause), .btn_reset(btn_reset),
    .sw_adj(sw_adj), .sw_sel(sw_sel),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .digit_blank(digit_blank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [3:0] M1 = 4'b0001;  // clock1Hz
  localparam logic [3:0] M2 = 4'b0010;  // clock2Hz
  localparam logic [3:0] MP = 4'b0100;  // btn_pause
  localparam logic [3:0] MR = 4'b1000;  // btn_reset

`ifdef BLINK_EN
  localparam logic [3:0] B_MIN = 4'b1100;
  localparam logic [3:0] B_SEC = 4'b0011;
`else
  localparam logic [3:0] B_MIN = 4'b0000;
  localparam logic [3:0] B_SEC = 4'b0000;
`endif

  typedef struct {
    logic [15:0] t;
    logic        r;
    logic [3:0]  b;
    int          due;
    int          tag;
  } exp_t;

  exp_t q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  function automatic logic [15:0] bcd(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic push(input logic [15:0] t, input logic r, input logic [3:0] b, input int tag);
    exp_t e;
    e.t = t; e.r = r; e.b = b; e.due = cyc + 1; e.tag = tag;
    q.push_back(e);
  endtask

  // Raise the masked levels for one cycle, then drop them for one cycle.
  task automatic pulse(input logic [3:0] mask, input bit chk, input logic [15:0] t,
                       input logic r, input logic [3:0] b, input int tag);
    clock1Hz  = mask[0];
    clock2Hz  = mask[1];
    btn_pause = mask[2];
    btn_reset = mask[3];
    if (chk) push(t, r, b, tag);
    @(negedge clk);
    clock1Hz = 1'b0; clock2Hz = 1'b0; btn_pause = 1'b0; btn_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_sw(input logic adj, input logic sel, input bit chk, input logic [15:0] t,
                        input logic r, input logic [3:0] b, input int tag);
    sw_adj = adj;
    sw_sel = sel;
    if (chk) push(t, r, b, tag);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [15:0] act;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e   = q.pop_front();
        act = {min_tens, min_ones, sec_tens, sec_ones};
        chk_cnt++;
        if (e.due == cyc && act == e.t && running == e.r && digit_blank == e.b)
          pass_cnt++;
        else
          $display("FAIL tag%0d cyc%0d: got time=%h running=%b blank=%b, required time=%h running=%b blank=%b",
                   e.tag, cyc, act, running, digit_blank, e.t, e.r, e.b);
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    clock1Hz = 1'b0; clock2Hz = 1'b0; clockBlink = 1'b0;
    btn_pause = 1'b0; btn_reset = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;

    @(negedge clk);
    push(16'h0000, 1'b0, 4'b0000, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Start and count one full minute.
    pulse(MP, 1, 16'h0000, 1'b1, 4'b0000, 1);
    for (int i = 1; i <= 60; i++) pulse(M1, 1, bcd(i / 60, i % 60), 1'b1, 4'b0000, 2);
    push(16'h0100, 1'b1, 4'b0000, 3);
    @(negedge clk);

    // Preload 59:58 through ADJUST, return to RUN, cross the full wrap.
    set_sw(1'b1, 1'b0, 1, 16'h0100, 1'b0, 4'b0000, 4);
    for (int m = 2; m <= 59; m++) pulse(M2, m == 59, bcd(m, 0), 1'b0, 4'b0000, 5);
    set_sw(1'b1, 1'b1, 0, 16'h0000, 1'b0, 4'b0000, 0);
    for (int s = 1; s <= 58; s++) pulse(M2, s == 58, bcd(59, s), 1'b0, 4'b0000, 6);
    set_sw(1'b0, 1'b1, 1, 16'h5958, 1'b1, 4'b0000, 7);
    pulse(M1, 1, 16'h5959, 1'b1, 4'b0000, 8);
    pulse(M1, 1, 16'h0000, 1'b1, 4'b0000, 9);
    pulse(M1, 1, 16'h0001, 1'b1, 4'b0000, 10);
    for (int s = 2; s <= 10; s++) pulse(M1, s == 10, bcd(0, s), 1'b1, 4'b0000, 11);

    // Seconds adjust from 00:10: 55 ticks wrap to 00:05, 1 Hz ignored.
    set_sw(1'b1, 1'b1, 1, 16'h0010, 1'b0, 4'b0000, 12);
    for (int k = 1; k <= 20; k++) pulse(M2, k == 20, bcd(0, 10 + k), 1'b0, 4'b0000, 13);
    repeat (3) pulse(M1, 1, 16'h0030, 1'b0, 4'b0000, 14);
    for (int k = 21; k <= 55; k++)
      pulse(M2, (k == 50) || (k == 55), bcd(0, (10 + k) % 60), 1'b0, 4'b0000, 15);
    set_sw(1'b0, 1'b1, 1, 16'h0005, 1'b1, 4'b0000, 16);

    // Pause, adjust to 12:34 while paused, ticks ignored, reset clears.
    pulse(MP, 1, 16'h0005, 1'b0, 4'b0000, 17);
    set_sw(1'b1, 1'b0, 1, 16'h0005, 1'b0, 4'b0000, 18);
    for (int m = 1; m <= 12; m++) pulse(M2, m == 12, bcd(m, 5), 1'b0, 4'b0000, 19);
    set_sw(1'b1, 1'b1, 0, 16'h0000, 1'b0, 4'b0000, 0);
    for (int s = 6; s <= 34; s++) pulse(M2, s == 34, bcd(12, s), 1'b0, 4'b0000, 20);
    set_sw(1'b0, 1'b1, 1, 16'h1234, 1'b0, 4'b0000, 21);
    repeat (5) pulse(M1, 1, 16'h1234, 1'b0, 4'b0000, 22);
    pulse(MR, 1, 16'h0000, 1'b0, 4'b0000, 23);

    // Same-cycle pause+tick and reset+tick in RUN.
    pulse(MP, 1, 16'h0000, 1'b1, 4'b0000, 24);
    for (int s = 1; s <= 7; s++) pulse(M1, s == 7, bcd(0, s), 1'b1, 4'b0000, 25);
    pulse(MP | M1, 1, 16'h0008, 1'b0, 4'b0000, 26);
    pulse(MP, 1, 16'h0008, 1'b1, 4'b0000, 27);
    pulse(MR | M1, 1, 16'h0000, 1'b0, 4'b0000, 28);

    // Tick coinciding with leaving ADJUST is dropped.
    pulse(MP, 1, 16'h0000, 1'b1, 4'b0000, 29);
    set_sw(1'b1, 1'b1, 1, 16'h0000, 1'b0, 4'b0000, 30);
    sw_adj = 1'b0;
    clock2Hz = 1'b1;
    push(16'h0000, 1'b1, 4'b0000, 31);
    @(negedge clk);
    clock2Hz = 1'b0;
    @(negedge clk);

    // Reset inside ADJUST keeps ADJUST and clears saved_run.
    set_sw(1'b1, 1'b1, 1, 16'h0000, 1'b0, 4'b0000, 32);
    pulse(M2, 1, 16'h0001, 1'b0, 4'b0000, 33);
    pulse(MR, 1, 16'h0000, 1'b0, 4'b0000, 34);
    pulse(M2, 1, 16'h0001, 1'b0, 4'b0000, 35);
    set_sw(1'b0, 1'b1, 1, 16'h0001, 1'b0, 4'b0000, 36);

    // Async reset mid-count; levels held high across release do not fire.
    pulse(MP, 1, 16'h0001, 1'b1, 4'b0000, 37);
    pulse(M1, 1, 16'h0002, 1'b1, 4'b0000, 38);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000 && running == 1'b0) pass_cnt++;
    else $display("FAIL async_clear: got time=%h running=%b, required time=0000 running=0",
                  {min_tens, min_ones, sec_tens, sec_ones}, running);
    @(negedge clk);
    push(16'h0000, 1'b0, 4'b0000, 39);
    clock1Hz = 1'b1;
    btn_pause = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push(16'h0000, 1'b0, 4'b0000, 40);
    @(negedge clk);
    clock1Hz = 1'b0;
    btn_pause = 1'b0;
    @(negedge clk);
    pulse(MP, 1, 16'h0000, 1'b1, 4'b0000, 41);

    // Blink of the selected field in ADJUST.
    sw_sel = 1'b0; sw_adj = 1'b1; clockBlink = 1'b1;
    push(16'h0000, 1'b0, B_MIN, 42);
    @(negedge clk);
    clockBlink = 1'b0;
    push(16'h0000, 1'b0, 4'b0000, 43);
    @(negedge clk);
    clockBlink = 1'b1;
    push(16'h0000, 1'b0, B_MIN, 44);
    @(negedge clk);
    sw_sel = 1'b1;
    push(16'h0000, 1'b0, B_SEC, 45);
    @(negedge clk);
    sw_adj = 1'b0;
    push(16'h0000, 1'b1, 4'b0000, 46);
    @(negedge clk);
    clockBlink = 1'b0;
    @(negedge clk);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the stopwatch datapath.
- Consumes the divided clock outputs of masterCLK (clock1Hz, clock2Hz, clockBlink) as level inputs in the clk domain.
- Detects their rising edges and drives the MM:SS BCD time registers.
- Arbitrates between run, pause, reset and adjust requests from debounced buttons and switches.

Parameters:
- MAX_MIN, 59: highest minutes value before wrap to 0; legal range 1..99.
- MAX_SEC, 59: highest seconds value before wrap; fixed use 59, range 1..59.

Ports:
- clk  in  1  system clock, same clock that feeds masterCLK.
- rst_n  in  1  asynchronous active-low reset.
- clock1Hz  in  1  level from masterCLK, synchronous to clk.
- clock2Hz  in  1  level from masterCLK, synchronous to clk.
- clockBlink  in  1  level from masterCLK; used only with BLINK_EN.
- btn_pause  in  1  debounced level; each rising edge toggles run/pause.
- btn_reset  in  1  debounced level; rising edge clears the time.
- sw_adj  in  1  level; 1 = adjust mode.
- sw_sel  in  1  level; in adjust, 0 = minutes, 1 = seconds.
- min_tens  out  4  BCD minutes tens.
- min_ones  out  4  BCD minutes ones.
- sec_tens  out  4  BCD seconds tens.
- sec_ones  out  4  BCD seconds ones.
- running  out  1  1 while in RUN.
- digit_blank  out  4  per-digit blank request, bits {min_tens, min_ones, sec_tens, sec_ones}.

Behaviour:
- Reset (rst_n low, async): all digits 0, state PAUSED, running 0, digit_blank 0, all edge-detect registers 0, saved_run 0.
- Edge detect: rise = level & ~level_q, where level_q is the level registered on clk.
  - A level high on consecutive samples yields exactly one pulse.
  - All registered outputs change on the clk edge after the cycle in which rise is true (1-cycle latency).
- States: RUN, PAUSED, ADJUST.
  - RUN --pause_rise--> PAUSED
  - PAUSED --pause_rise--> RUN
  - RUN/PAUSED --sw_adj==1--> ADJUST; saved_run = (state==RUN)
  - ADJUST --sw_adj==0--> RUN if saved_run, else PAUSED
  - pause_rise in ADJUST is ignored and does not change saved_run.
- RUN, on tick1_rise: seconds +1.
  - Seconds wrap MAX_SEC -> 0 with carry to minutes.
  - Minutes wrap MAX_MIN -> 0.
  - At MAX_MIN:MAX_SEC the time becomes 00:00.
- ADJUST, on tick2_rise: the selected field only +1, wrapping at its own max, no carry.
  - The unselected field is frozen.
  - clock1Hz is ignored in ADJUST.
- PAUSED: time frozen; ticks ignored.
- Arithmetic: each field is held as 2 BCD digits; ones wraps 9 -> 0 and increments tens. Binary intermediates are not exposed.
- Priority within one cycle: reset_rise > mode change (sw_adj) > pause_rise > tick.
  - reset_rise sets time to 00:00 in any state. State becomes PAUSED unless in ADJUST, where it stays ADJUST and saved_run is cleared.
  - A tick in the same cycle as pause_rise in RUN is applied (increment and transition both occur).
  - A tick in the same cycle as a sw_adj change is dropped.
- sw_sel may change at any time in ADJUST; it takes effect on the next tick2_rise.
- running is registered and equals (next_state==RUN).
- rst_n asserted mid-count: immediate clear; the first rise after release requires a low-to-high transition seen after reset.

Optional Feature:
- BLINK_EN defined:
  - In ADJUST, the two digit_blank bits of the selected field follow the registered clockBlink level (1 = blank).
  - All bits are 0 outside ADJUST.
- BLINK_EN undefined:
  - digit_blank is tied to 0.
  - clockBlink is unused; its edge register is not built.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants ST_RUN=2'd0, ST_PAUSED=2'd1, ST_ADJUST=2'd2
  - digit-index constants for digit_blank bit positions
  - BCD_W=4
- Sub-module rise_detect (clk, rst_n, level, rise), instantiated for clock1Hz, clock2Hz, btn_pause and btn_reset.
- The BCD field incrementer is a local function, not a module.

Test Plan:
- Reset, then btn_pause pulse, then 60 clock1Hz rising edges -> running=1, time 01:00; each digit update lands exactly 1 clk after its edge.
- Preload to 59:58 via adjust, pause=RUN, 2 clock1Hz edges -> 59:59 then 00:00, no stuck carry.
- RUN at 00:10, sw_adj=1, sw_sel=1, 55 clock2Hz edges -> 00:05, minutes stay 00, clock1Hz edges ignored; sw_adj=0 -> running=1 again.
- PAUSED at 12:34, 5 clock1Hz edges -> still 12:34; btn_reset edge -> 00:00, running=0.
- Same-cycle btn_pause rise and clock1Hz rise in RUN at 00:07 -> 00:08 and PAUSED; same-cycle btn_reset and tick -> 00:00.
- With BLINK_EN, ADJUST, sw_sel=0, clockBlink toggling -> digit_blank alternates 4'b1100/4'b0000; leaving ADJUST -> 4'b0000. Without BLINK_EN -> always 0.
